// File: rtl/seq_tx_fmt.sv
`default_nettype none
// ============================================================================
//  Module      : seq_tx_fmt
//  Description : Formats one sequencer result as the ASCII line
//                "R<n>=<hex>\r\n". Bytes are handed to a UART transmitter
//                one at a time over a strobe/busy handshake. Results that
//                arrive while a line is in progress are dropped and counted.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_tx_fmt #(
    parameter int DATA_W = 8,
    parameter int REG_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] i_data,
    input  logic [REG_W-1:0]  i_reg,
    input  logic              i_valid,
    output logic              o_busy,
    input  logic              i_tx_busy,
    output logic [7:0]        o_byte,
    output logic              o_byte_stb,
    output logic [7:0]        o_drop_cnt
);

    localparam int c_DIGITS = DATA_W / 4;
    localparam int c_NB     = 5 + c_DIGITS;
    localparam int c_IDX_W  = $clog2(c_NB);

    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(c_NB - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_CR   = c_IDX_W'(c_NB - 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_GUARD = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [DATA_W-1:0]    r_data;
    logic [REG_W-1:0]     r_reg;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_IDX_W-1:0]   w_idx_nxt;
    logic [7:0]           r_byte;
    logic [7:0]           w_byte_nxt;
    logic                 r_stb;
    logic                 w_stb_nxt;
    logic                 r_busy;
    logic [7:0]           r_drop;
    logic                 w_capture;
    logic                 w_drop;
    logic [3:0]           w_nib;
    logic [7:0]           w_char;

    // Select the nibble for the current hex-digit position, MS nibble first
    always_comb begin
        w_nib = 4'h0;
        for (int k = 0; k < c_DIGITS; k++) begin
            if (r_idx == c_IDX_W'(k + 3)) begin
                w_nib = r_data[4*(c_DIGITS-1-k) +: 4];
            end
        end
    end

    // Map the byte index to the ASCII character of the line
    always_comb begin
        w_char = 8'h0A;
        if (r_idx == '0) begin
            w_char = 8'h52;
        end else if (r_idx == c_IDX_W'(1)) begin
            w_char = 8'h30 + 8'(r_reg);
        end else if (r_idx == c_IDX_W'(2)) begin
            w_char = 8'h3D;
        end else if (r_idx == c_IDX_CR) begin
            w_char = 8'h0D;
        end else if (r_idx == c_IDX_LAST) begin
            w_char = 8'h0A;
        end else if (w_nib < 4'd10) begin
            w_char = 8'h30 + {4'h0, w_nib};
        end else begin
            w_char = 8'h37 + {4'h0, w_nib};
        end
    end

    // Next-state and next-output logic of the line sequencer
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_byte_nxt  = r_byte;
        w_stb_nxt   = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_valid) begin
                    w_capture   = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!i_tx_busy) begin
                    w_byte_nxt  = w_char;
                    w_stb_nxt   = 1'b1;
                    w_state_nxt = ST_GUARD;
                end
            end
            // Transmitter busy may not have risen yet, so it is not looked at
            ST_GUARD: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (!i_tx_busy) begin
                    if (r_idx == c_IDX_LAST) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_idx_nxt   = r_idx + c_IDX_W'(1);
                        w_state_nxt = ST_SEND;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // A strobe outside IDLE (including the exit cycle of WAIT) is a drop
    assign w_drop = i_valid && (r_state != ST_IDLE) && (r_drop != 8'hFF);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered datapath: captured result, byte index, outputs, drop counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data <= '0;
            r_reg  <= '0;
            r_idx  <= '0;
            r_byte <= 8'h00;
            r_stb  <= 1'b0;
            r_busy <= 1'b0;
            r_drop <= 8'h00;
        end else begin
            r_idx  <= w_idx_nxt;
            r_byte <= w_byte_nxt;
            r_stb  <= w_stb_nxt;
            r_busy <= (w_state_nxt != ST_IDLE);
            if (w_capture) begin
                r_data <= i_data;
                r_reg  <= i_reg;
            end
            if (w_drop) begin
                r_drop <= r_drop + 8'd1;
            end
        end
    end

    assign o_busy     = r_busy;
    assign o_byte     = r_byte;
    assign o_byte_stb = r_stb;
    assign o_drop_cnt = r_drop;

endmodule
`default_nettype wire
